ase_pcie_ss_tx_pkt_buffer: RTL and testbench
============================================

ASE_PCIE_SS_TX_PKT_BUFFER -- requirements
Module: ase_pcie_ss_tx_pkt_buffer

Interface
REQ-001 SHALL have parameter DEPTH_BEATS, default 64, meaning buffer capacity in beats; power of two, at least 4.
REQ-002 SHALL have parameter TDATA_WIDTH, default ofs_pcie_ss_cfg_pkg::TDATA_WIDTH, meaning data width in bits.
REQ-003 SHALL have parameter TUSER_WIDTH, default ofs_pcie_ss_cfg_pkg::TUSER_VENDOR_WIDTH, meaning tuser_vendor width.
REQ-004 SHALL have port clk, input, 1, the single clock; reset is synchronous and active-low.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have ports in_tvalid/in_tready/in_tlast, input/output/input, 1 each: AFU TX stream handshake.
REQ-007 SHALL have ports in_tdata/in_tkeep/in_tuser_vendor, input, TDATA_WIDTH/TDATA_WIDTH/8/TUSER_WIDTH: AFU TX beat.
REQ-008 SHALL have ports out_tvalid/out_tready/out_tlast, output/input/output, 1 each: stream to the emulator pcie_tx_if sink.
REQ-009 SHALL have ports out_tdata/out_tkeep/out_tuser_vendor, output, same widths: beat to the emulator.
REQ-010 SHALL have port overflow_err, output, 1: sticky, a packet exceeded DEPTH_BEATS.
REQ-011 SHALL have ports stat_pkts/stat_beats, output, 32 each: forwarded packet/beat counters.

Function
REQ-012 SHALL store-and-forward: no beat of a packet leaves until its tlast beat is written, except per REQ-019.
REQ-013 SHALL assert in_tready exactly when occupancy < DEPTH_BEATS; a beat is accepted when in_tvalid && in_tready.
REQ-014 SHALL keep occupancy counter log2(DEPTH_BEATS)+1 bits wide; read/write pointers wrap modulo DEPTH_BEATS.
REQ-015 SHALL keep complete-packet counter: +1 on accepted tlast beat, -1 on output tlast handshake, unchanged when both occur in one cycle.
REQ-016 SHALL run output FSM IDLE/SEND: IDLE->SEND when complete count > 0 (or force mode); SEND->IDLE on out tlast handshake when complete count after update is 0, else remain SEND.
REQ-017 SHALL register outputs; out_tvalid first rises no earlier than one cycle after the tlast beat is accepted; back-to-back packets stream with no bubbles.
REQ-018 SHALL hold out_t* stable while out_tvalid && !out_tready (AXI-S rule).
REQ-019 SHALL, when occupancy == DEPTH_BEATS with complete count 0, set overflow_err and enter cut-through for that packet until its tlast is forwarded.
REQ-020 SHALL allow simultaneous write and read when full: read frees the slot, in_tready reasserts next cycle only.
REQ-021 SHALL increment stat_beats per output beat and stat_pkts per output tlast, wrapping at 2^32.

Reset
REQ-022 SHALL, with rst_n low at a clk edge, clear pointers, counters, FSM to IDLE, overflow_err, stats; out_tvalid=0, out_tlast=0, out data=0, in_tready=0.
REQ-023 SHALL discard any partial or buffered packet on reset mid-operation; in_tready reasserts first cycle after rst_n high.

Configuration
REQ-024 SHALL compile stat counters only with ASE_PCIE_SS_TX_PKT_BUFFER_STATS_EN defined; without it stat_pkts/stat_beats are constant 0 and no counter flops exist.

Structure
REQ-025 SHALL place t_tdata, t_tkeep, t_tuser typedefs and beat struct t_tx_beat {tdata,tkeep,tuser,tlast} in ase_pcie_ss_pkg.
REQ-026 SHALL use one sub-module ase_pcie_ss_tx_fifo_mem: simple dual-port registered-read storage of t_tx_beat, DEPTH_BEATS entries.

Verification
REQ-027 SHALL test single 3-beat packet, out_tready=1 -> out_tvalid rises cycle after beat 3 accepted; 3 beats in order, stat_pkts=1, stat_beats=3.
REQ-028 SHALL test 1-beat packets every cycle, out_tready=1 -> continuous output, in_tready never drops, no bubbles after first.
REQ-029 SHALL test out_tready=0 with 64 beats of 4-beat packets written -> in_tready=0 at occupancy 64; release -> 64 beats exit in order.
REQ-030 SHALL test 80-beat packet, DEPTH_BEATS=64 -> overflow_err=1, all 80 beats forwarded intact in cut-through.
REQ-031 SHALL test rst_n low mid-packet (2 of 4 beats) -> out_tvalid=0, counters 0, next packet forwarded cleanly.
REQ-032 SHALL test build without STATS_EN -> stat outputs constantly 0 under traffic of REQ-028.

Source files
------------

// File: rtl/ase_pcie_ss_pkg.sv
// ase_pcie_ss_pkg: beat types and output FSM states for the TX packet buffer
package ase_pcie_ss_pkg;
  typedef logic [ofs_pcie_ss_cfg_pkg::TDATA_WIDTH-1:0] t_tdata;
  typedef logic [ofs_pcie_ss_cfg_pkg::TDATA_WIDTH/8-1:0] t_tkeep;
  typedef logic [ofs_pcie_ss_cfg_pkg::TUSER_VENDOR_WIDTH-1:0] t_tuser;
  typedef struct packed {
    t_tdata tdata;
    t_tkeep tkeep;
    t_tuser tuser;
    logic   tlast;
  } t_tx_beat;
  typedef enum logic {IDLE, SEND} t_state;
endpackage

// File: rtl/ofs_pcie_ss_cfg_pkg.sv
// ofs_pcie_ss_cfg_pkg: PCIe subsystem stream widths used as buffer defaults
package ofs_pcie_ss_cfg_pkg;
  localparam int TDATA_WIDTH = 512;
  localparam int TUSER_VENDOR_WIDTH = 10;
endpackage

// File: rtl/ase_pcie_ss_tx_fifo_mem.sv
// ase_pcie_ss_tx_fifo_mem: simple dual-port beat storage with registered, resettable read port
module ase_pcie_ss_tx_fifo_mem
  import ase_pcie_ss_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  t_tx_beat                 wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output t_tx_beat                 rdata_o
);
  t_tx_beat mem_q [DEPTH];
  t_tx_beat rdata_q;
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  always_ff @(posedge clk)
    if (!rst_n) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/ase_pcie_ss_tx_pkt_buffer.sv
// ase_pcie_ss_tx_pkt_buffer: store-and-forward AFU TX buffer; stat counters built only with ASE_PCIE_SS_TX_PKT_BUFFER_STATS_EN
module ase_pcie_ss_tx_pkt_buffer
  import ase_pcie_ss_pkg::*;
#(
  parameter int DEPTH_BEATS = 64,
  parameter int TDATA_WIDTH = ofs_pcie_ss_cfg_pkg::TDATA_WIDTH,
  parameter int TUSER_WIDTH = ofs_pcie_ss_cfg_pkg::TUSER_VENDOR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_tvalid,
  output logic                     in_tready,
  input  logic                     in_tlast,
  input  logic [TDATA_WIDTH-1:0]   in_tdata,
  input  logic [TDATA_WIDTH/8-1:0] in_tkeep,
  input  logic [TUSER_WIDTH-1:0]   in_tuser_vendor,
  output logic                     out_tvalid,
  input  logic                     out_tready,
  output logic                     out_tlast,
  output logic [TDATA_WIDTH-1:0]   out_tdata,
  output logic [TDATA_WIDTH/8-1:0] out_tkeep,
  output logic [TUSER_WIDTH-1:0]   out_tuser_vendor,
  output logic                     overflow_err,
  output logic [31:0]              stat_pkts,
  output logic [31:0]              stat_beats
);
  localparam int AW = $clog2(DEPTH_BEATS);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH_BEATS);
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] occ_q, occ_d, cnt_q, cnt_d, mem_beats, mem_pkts;
  logic rdy_q, vld_q, ct_q, ovf_q, acc, hs, last_hs, held_last, load;
  t_state state_q, state_d;
  t_tx_beat wbeat, rbeat;
  // The read register doubles as the output register; occupancy counts it,
  // so mem_beats/mem_pkts are what is still waiting inside the array.
  always_comb begin
    wbeat = '{tdata: in_tdata, tkeep: in_tkeep, tuser: in_tuser_vendor, tlast: in_tlast};
    acc = in_tvalid && rdy_q;
    hs = vld_q && out_tready;
    last_hs = hs && rbeat.tlast;
    held_last = vld_q && rbeat.tlast;
    occ_d = occ_q + (AW+1)'(acc) - (AW+1)'(hs);
    cnt_d = cnt_q + (AW+1)'(acc && in_tlast) - (AW+1)'(last_hs);
    mem_beats = occ_q - (AW+1)'(vld_q);
    mem_pkts = cnt_q - (AW+1)'(held_last);
    state_d = state_q == IDLE ? ((cnt_q != 0 || ct_q) ? SEND : IDLE)
                              : ((last_hs && cnt_d == 0) ? IDLE : SEND);
    load = state_d == SEND && mem_beats != 0 && (mem_pkts != 0 || (ct_q && !held_last))
           && (!vld_q || out_tready);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b0;
      vld_q <= 1'b0;
      ct_q <= 1'b0;
      ovf_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(acc);
      rd_ptr_q <= rd_ptr_q + AW'(load);
      occ_q <= occ_d;
      cnt_q <= cnt_d;
      rdy_q <= occ_d < FULL;
      vld_q <= load || (vld_q && !out_tready);
      state_q <= state_d;
      if (occ_q == FULL && cnt_q == 0) begin
        ct_q <= 1'b1;
        ovf_q <= 1'b1;
      end else if (last_hs) ct_q <= 1'b0;
    end
  ase_pcie_ss_tx_fifo_mem #(.DEPTH(DEPTH_BEATS)) u_mem (
    .clk(clk),
    .rst_n(rst_n),
    .we_i(acc),
    .waddr_i(wr_ptr_q),
    .wdata_i(wbeat),
    .re_i(load),
    .raddr_i(rd_ptr_q),
    .rdata_o(rbeat)
  );
  assign in_tready = rdy_q;
  assign out_tvalid = vld_q;
  assign out_tlast = rbeat.tlast;
  assign out_tdata = rbeat.tdata;
  assign out_tkeep = rbeat.tkeep;
  assign out_tuser_vendor = rbeat.tuser;
  assign overflow_err = ovf_q;
`ifdef ASE_PCIE_SS_TX_PKT_BUFFER_STATS_EN
  logic [31:0] pkts_q, beats_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      pkts_q <= '0;
      beats_q <= '0;
    end else begin
      pkts_q <= pkts_q + 32'(last_hs);
      beats_q <= beats_q + 32'(hs);
    end
  assign stat_pkts = pkts_q;
  assign stat_beats = beats_q;
`else
  assign stat_pkts = '0;
  assign stat_beats = '0;
`endif
endmodule

// File: tb/tb_ase_pcie_ss_tx_pkt_buffer.sv
// tb_ase_pcie_ss_tx_pkt_buffer: scoreboard bench for the TX packet buffer
module tb_ase_pcie_ss_tx_pkt_buffer;
  localparam int TW = 512;
  localparam int KW = 64;
  localparam int UW = 10;
`ifdef ASE_PCIE_SS_TX_PKT_BUFFER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 0, rst_n = 0;
  logic in_tvalid = 0, in_tlast = 0, out_tready = 0;
  logic in_tready, out_tvalid, out_tlast, overflow_err;
  logic [TW-1:0] in_tdata = '0, out_tdata;
  logic [KW-1:0] in_tkeep = '0, out_tkeep;
  logic [UW-1:0] in_tuser_vendor = '0, out_tuser_vendor;
  logic [31:0] stat_pkts, stat_beats;
  always #5 clk = ~clk;
  ase_pcie_ss_tx_pkt_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tuser_vendor(in_tuser_vendor),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tuser_vendor(out_tuser_vendor),
    .overflow_err(overflow_err), .stat_pkts(stat_pkts), .stat_beats(stat_beats)
  );
  typedef struct {int id; bit last;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_tests = 0, n_fail = 0;
  logic stall = 0, pl;
  logic [TW-1:0] pd;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Monitor: pops the scoreboard on every output handshake and checks AXI-S hold.
  always @(negedge clk) begin
    if (!rst_n) stall = 0;
    else begin
      if (stall) begin
        n_tests++;
        if (!out_tvalid || out_tdata !== pd || out_tlast !== pl) begin
          n_fail++;
          $display("FAIL hold: got vld=%0b d=%0h l=%0b expected vld=1 d=%0h l=%0b",
                   out_tvalid, out_tdata[31:0], out_tlast, pd[31:0], pl);
        end
      end
      if (out_tvalid && out_tready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got d=%0h expected no beat", out_tdata[31:0]);
        end else begin
          e = sb.pop_front();
          if (out_tdata !== {16{32'(e.id)}} || out_tkeep !== {2{32'(e.id)}} ||
              out_tuser_vendor !== UW'(e.id) || out_tlast !== e.last) begin
            n_fail++;
            $display("FAIL beat: got d=%0h k=%0h u=%0h l=%0b expected id=%0h l=%0b",
                     out_tdata[31:0], out_tkeep[31:0], out_tuser_vendor, out_tlast, e.id, e.last);
          end
        end
      end
      stall = out_tvalid && !out_tready;
      pd = out_tdata;
      pl = out_tlast;
    end
  end
  task automatic send_beat(int id, bit last);
    int w = 0;
    in_tvalid = 1;
    in_tdata = {16{32'(id)}};
    in_tkeep = {2{32'(id)}};
    in_tuser_vendor = UW'(id);
    in_tlast = last;
    while (!in_tready && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_tready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_tready=0 expected 1 (id %0d)", id);
      in_tvalid = 0;
    end else begin
      sb.push_back('{id, last});
      @(posedge clk); #1;
    end
  endtask
  task automatic drain();
    int w = 0;
    in_tvalid = 0;
    while ((sb.size() != 0 || out_tvalid) && w < 1000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain_left", 64'(sb.size()), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int bub, drops;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_in_tready", 64'(in_tready), 0);
    chk("rst_out_tvalid", 64'(out_tvalid), 0);
    chk("rst_out_tlast", 64'(out_tlast), 0);
    chk("rst_out_tdata", out_tdata[63:0], 0);
    chk("rst_overflow", 64'(overflow_err), 0);
    chk("rst_stats", {stat_pkts, stat_beats}, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("rst_release_tready", 64'(in_tready), 1);
    // single 3-beat packet
    out_tready = 1;
    send_beat(1, 0);
    send_beat(2, 0);
    send_beat(3, 1);
    chk("sf_no_early_valid", 64'(out_tvalid), 0);
    in_tvalid = 0;
    @(posedge clk); #1;
    chk("sf_valid_rise", 64'(out_tvalid), 1);
    drain();
    chk("stat_pkts_1", 64'(stat_pkts), STATS ? 64'd1 : 64'd0);
    chk("stat_beats_1", 64'(stat_beats), STATS ? 64'd3 : 64'd0);
    // 1-beat packets every cycle
    bub = 0;
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      if (i >= 2 && !out_tvalid) bub++;
      if (!in_tready) drops++;
      send_beat(100 + i, 1);
    end
    in_tvalid = 0;
    chk("b2b_bubbles", 64'(bub), 0);
    chk("b2b_tready_drops", 64'(drops), 0);
    drain();
    chk("stat_pkts_2", 64'(stat_pkts), STATS ? 64'd21 : 64'd0);
    chk("stat_beats_2", 64'(stat_beats), STATS ? 64'd23 : 64'd0);
    // fill to capacity with output stalled
    out_tready = 0;
    for (int p = 0; p < 16; p++)
      for (int b = 0; b < 4; b++) send_beat(200 + p * 4 + b, b == 3);
    in_tvalid = 0;
    chk("full_tready", 64'(in_tready), 0);
    chk("full_out_valid", 64'(out_tvalid), 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("full_tready_held", 64'(in_tready), 0);
    out_tready = 1;
    @(posedge clk); #1;
    chk("full_tready_return", 64'(in_tready), 1);
    drain();
    chk("full_no_overflow", 64'(overflow_err), 0);
    chk("stat_pkts_3", 64'(stat_pkts), STATS ? 64'd37 : 64'd0);
    chk("stat_beats_3", 64'(stat_beats), STATS ? 64'd87 : 64'd0);
    // oversize packet forces cut-through
    for (int b = 0; b < 80; b++) begin
      send_beat(1000 + b, b == 79);
      if (b == 70) begin
        chk("ct_overflow_set", 64'(overflow_err), 1);
        chk("ct_streaming", 64'(out_tvalid), 1);
      end
    end
    drain();
    chk("ct_overflow_sticky", 64'(overflow_err), 1);
    chk("stat_pkts_4", 64'(stat_pkts), STATS ? 64'd38 : 64'd0);
    chk("stat_beats_4", 64'(stat_beats), STATS ? 64'd167 : 64'd0);
    // reset mid-packet
    send_beat(2000, 0);
    send_beat(2001, 0);
    in_tvalid = 0;
    rst_n = 0;
    sb.delete();
    @(posedge clk); #1;
    chk("mid_rst_out_tvalid", 64'(out_tvalid), 0);
    chk("mid_rst_in_tready", 64'(in_tready), 0);
    chk("mid_rst_overflow", 64'(overflow_err), 0);
    chk("mid_rst_stats", {stat_pkts, stat_beats}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    chk("mid_rst_tready_back", 64'(in_tready), 1);
    chk("mid_rst_no_output", 64'(out_tvalid), 0);
    for (int b = 0; b < 4; b++) send_beat(3000 + b, b == 3);
    drain();
    chk("stat_pkts_5", 64'(stat_pkts), STATS ? 64'd1 : 64'd0);
    chk("stat_beats_5", 64'(stat_beats), STATS ? 64'd4 : 64'd0);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
